// File: rtl/data_mem_arbiter.sv
// Two-master arbiter in front of a single-port data memory.
// Round-robin on ties, bounded ownership bursts, registered per-port read data.
`timescale 1ns/1ps

module data_mem_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Address,
  output logic [31:0] Write_data,
  input  logic [31:0] Read_data
);

  // state | meaning
  // IDLE  | nobody owns the memory, arbitrate next edge
  // OWN0  | m0 owns the memory, its req is granted directly
  // OWN1  | m1 owns the memory, its req is granted directly
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  state_t      state_q, state_d;
  logic        last_q, last_d;     // 1 = m1 was served last
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  cnt_inc;
  logic        own1, own_req, oth_req, beat, own_we;
  logic        m0_rvalid_q, m1_rvalid_q;
  logic [31:0] m0_rdata_q, m1_rdata_q;

  assign own1    = (state_q == OWN1);
  assign own_req = own1 ? m1_req : m0_req;
  assign oth_req = own1 ? m0_req : m1_req;
  assign cnt_inc = cnt_q + 4'd1;

  assign m0_gnt = (state_q == OWN0) & m0_req;
  assign m1_gnt = own1 & m1_req;
  assign beat   = m0_gnt | m1_gnt;
  assign own_we = own1 ? m1_we : m0_we;

  assign MemWrite   = beat & own_we;
  assign MemRead    = beat & ~own_we;
  assign Address    = beat ? (own1 ? m1_addr : m0_addr) : 32'h0;
  assign Write_data = beat ? (own1 ? m1_wdata : m0_wdata) : 32'h0;

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

  // Next ownership, last-served pointer and burst count.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (m0_req && (!m1_req || last_q)) begin
          state_d = OWN0;
          last_d  = 1'b0;
          cnt_d   = 4'd0;
        end else if (m1_req) begin
          state_d = OWN1;
          last_d  = 1'b1;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        if (!own_req) begin
          // Owner went quiet: hand over directly if the other side waits.
          if (oth_req) begin
            state_d = own1 ? OWN0 : OWN1;
            last_d  = ~own1;
            cnt_d   = 4'd0;
          end else begin
            state_d = IDLE;
          end
        end else if (cnt_inc == BURST_LIM) begin
          // Burst limit reached: yield only if someone is waiting.
          cnt_d = 4'd0;
          if (oth_req) begin
            state_d = own1 ? OWN0 : OWN1;
            last_d  = ~own1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture read data per port and pulse rvalid the cycle after the beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= 32'h0;
      m1_rdata_q  <= 32'h0;
    end else begin
      m0_rvalid_q <= m0_gnt & ~m0_we;
      m1_rvalid_q <= m1_gnt & ~m1_we;
      if (m0_gnt && !m0_we) m0_rdata_q <= Read_data;
      if (m1_gnt && !m1_we) m1_rdata_q <= Read_data;
    end
  end

endmodule
